// File: rtl/core_pkg.sv
// Shared definitions for the scalar/vector core front end: opcodes,
// instruction field positions and the vector register type.
package core_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_ADDI = 4'h3,
    OP_VADD = 4'h4,
    OP_LD   = 4'h5,
    OP_VLD  = 4'h6,
    OP_ST   = 4'h7,
    OP_VST  = 4'h8,
    OP_BEQ  = 4'h9,
    OP_JMP  = 4'hA
  } opcode_e;

  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;
  localparam int IMM_W   = 16;

  localparam int LANES = 16;
  typedef logic [LANES-1:0][31:0] vec_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/fd_pipe_reg.sv
// Fetch/decode pipe register: carries the fetched instruction and its PC
// into D/E; reset or a taken-branch flush loads a NOP.
module fd_pipe_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);
  import core_pkg::*;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  assign instr_d = flush_i ? INSTR_NOP : instr_i;
  assign pc_d    = pc_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= INSTR_NOP;
      pc_q    <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/vector_core_frontend.sv
// Two-stage scalar/vector core: F (PC -> instruction ROM) and D/E
// (decode, execute, writeback), driving a 16-lane data-memory bus.
module vector_core_frontend #(
  parameter int    IMEM_DEPTH = 256,
  parameter string IMEM_FILE  = "program.hex",
  parameter int    LANES      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0][31:0] dataRead,
  output logic [LANES-1:0][31:0] dataWrite,
  output logic                  memWrite,
  output logic [17:0]           addr,
  output logic                  vec_scalar,
  output logic [31:0]           pc
);
  import core_pkg::*;

  localparam int IDX_W = $clog2(IMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc_q, pc_d, instr_f;
  logic [31:0] fd_instr, fd_pc;
  logic        taken;
  logic [31:0] target;

  // Power-of-two depth: the low PC bits give the wrapping ROM index.
  assign instr_f = imem[pc_q[IDX_W-1:0]];

  fd_pipe_reg u_fd (
    .clk     (clk),
    .rst     (rst),
    .flush_i (taken),
    .instr_i (instr_f),
    .pc_i    (pc_q),
    .instr_o (fd_instr),
    .pc_o    (fd_pc)
  );

  opcode_e     op;
  logic [3:0]  rd, rs1, rs2;
  logic [31:0] imm_s, rs1_val, rs2_val;

  logic [31:0]            sreg_q [16];
  logic [LANES-1:0][31:0] vreg_q [4];

  assign op      = opcode_e'(fd_instr[OP_LSB +: 4]);
  assign rd      = fd_instr[RD_LSB +: 4];
  assign rs1     = fd_instr[RS1_LSB +: 4];
  assign rs2     = fd_instr[RS2_LSB +: 4];
  assign imm_s   = {{(32-IMM_W){fd_instr[IMM_W-1]}}, fd_instr[IMM_W-1:0]};
  assign rs1_val = sreg_q[rs1];
  assign rs2_val = sreg_q[rs2];

  logic                   s_we, v_we;
  logic [31:0]            s_wdata;
  logic [LANES-1:0][31:0] v_wdata;

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    dataWrite  = '0;
    memWrite   = 1'b0;
    vec_scalar = 1'b0;
    addr       = '0;
    taken      = 1'b0;
    target     = '0;
    s_we       = 1'b0;
    s_wdata    = '0;
    v_we       = 1'b0;
    v_wdata    = '0;

    if (op inside {OP_LD, OP_VLD, OP_ST, OP_VST})
      addr = rs1_val[17:0] + imm_s[17:0];

    case (op)
      OP_ADD:  begin s_we = 1'b1; s_wdata = rs1_val + rs2_val; end
      OP_SUB:  begin s_we = 1'b1; s_wdata = rs1_val - rs2_val; end
      OP_ADDI: begin s_we = 1'b1; s_wdata = rs1_val + imm_s;   end
      OP_LD:   begin s_we = 1'b1; s_wdata = dataRead[0];       end
      OP_VADD: begin
        v_we = 1'b1;
        for (int l = 0; l < LANES; l++)
          v_wdata[l] = vreg_q[rs1[1:0]][l] + vreg_q[rs2[1:0]][l];
      end
      OP_VLD: begin
        v_we       = 1'b1;
        v_wdata    = dataRead;
        vec_scalar = 1'b1;
      end
      OP_ST: begin
        dataWrite[0] = rs2_val;
        memWrite     = !rst;
      end
      OP_VST: begin
        dataWrite  = vreg_q[rs2[1:0]];
        memWrite   = !rst;
        vec_scalar = 1'b1;
      end
      OP_BEQ: begin
        taken  = (rs1_val == rs2_val);
        target = fd_pc + imm_s;
      end
      OP_JMP: begin
        taken  = 1'b1;
        target = {16'h0000, fd_instr[15:0]};
      end
      default: ;
    endcase

    // r0 reads as zero because it is never written after reset.
    if (rd == 4'd0) s_we = 1'b0;
  end

  assign pc_d = taken ? target : pc_q + 32'd1;
  assign pc   = pc_q;

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  // NOTE: the register files are flops with a full reset so a mid-program
  // reset returns the core to a known state; the instruction ROM is not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) sreg_q[i] <= '0;
      for (int i = 0; i < 4; i++)  vreg_q[i] <= '0;
    end else begin
      if (s_we) sreg_q[rd]      <= s_wdata;
      if (v_we) vreg_q[rd[1:0]] <= v_wdata;
    end
  end

endmodule

// File: tb/tb_vector_core_frontend.sv
// Directed bench for vector_core_frontend: loads a small program into the
// ROM and checks arithmetic, memory, vector, branch, reset and wrap behaviour.
module tb_vector_core_frontend;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  vec_t        data_read;
  vec_t        data_write;
  logic        mem_write;
  logic [17:0] addr;
  logic        vec_scalar;
  logic [31:0] pc;

  int errors = 0;
  int checks = 0;

  vector_core_frontend #(
    .IMEM_DEPTH (256),
    .IMEM_FILE  (""),
    .LANES      (LANES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dataRead   (data_read),
    .dataWrite  (data_write),
    .memWrite   (mem_write),
    .addr       (addr),
    .vec_scalar (vec_scalar),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
    dut.imem[0]  = 32'h31000005; // ADDI r1,r0,5
    dut.imem[1]  = 32'h32000007; // ADDI r2,r0,7
    dut.imem[2]  = 32'h13120000; // ADD  r3,r1,r2
    dut.imem[3]  = 32'h24120000; // SUB  r4,r1,r2
    dut.imem[4]  = 32'h70030010; // ST   r3 -> r0+0x10
    dut.imem[5]  = 32'h55000020; // LD   r5 <- r0+0x20
    dut.imem[6]  = 32'h61000040; // VLD  v1 <- r0+0x40
    dut.imem[7]  = 32'h42110000; // VADD v2,v1,v1
    dut.imem[8]  = 32'h80120003; // VST  v2 -> r1+3
    dut.imem[9]  = 32'h90110004; // BEQ  r1,r1,+4 (taken -> 13)
    dut.imem[10] = 32'h36000001; // skipped
    dut.imem[11] = 32'h36000002; // skipped
    dut.imem[12] = 32'h36000003; // skipped
    dut.imem[13] = 32'h90120004; // BEQ  r1,r2,+4 (not taken)
    dut.imem[14] = 32'h37000009; // ADDI r7,r0,9
    dut.imem[15] = 32'hA0000000; // JMP  0
    dut.imem[16] = 32'h36000063; // unreachable
    data_read = '0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_memwrite", 32'(mem_write), 32'h0);
    check("rst_vec_scalar", 32'(vec_scalar), 32'h0);
    check("rst_addr", 32'(addr), 32'h0);
    rst = 1'b0;

    @(negedge clk); // D = ADDI r1
    check("first_word_in_d", dut.fd_instr, 32'h31000005);
    check("pc_after_release", pc, 32'h1);
    @(negedge clk); // D = ADDI r2
    check("r1", dut.sreg_q[1], 32'd5);
    @(negedge clk); // D = ADD
    check("r2", dut.sreg_q[2], 32'd7);
    @(negedge clk); // D = SUB
    check("add_r3", dut.sreg_q[3], 32'd12);
    @(negedge clk); // D = ST
    check("sub_r4", dut.sreg_q[4], 32'hFFFFFFFE);
    check("st_addr", 32'(addr), 32'h10);
    check("st_memwrite", 32'(mem_write), 32'h1);
    check("st_data0", data_write[0], 32'd12);
    check("st_lane1_zero", data_write[1], 32'h0);
    check("st_vec_scalar", 32'(vec_scalar), 32'h0);
    @(negedge clk); // D = LD
    check("ld_memwrite_drop", 32'(mem_write), 32'h0);
    check("ld_addr", 32'(addr), 32'h20);
    data_read[0] = 32'h0000CAFE;
    @(negedge clk); // D = VLD
    check("ld_r5", dut.sreg_q[5], 32'h0000CAFE);
    for (int l = 0; l < LANES; l++) data_read[l] = 32'(l);
    check("vld_vec_scalar", 32'(vec_scalar), 32'h1);
    check("vld_addr", 32'(addr), 32'h40);
    @(negedge clk); // D = VADD
    data_read = '0;
    @(negedge clk); // D = VST
    for (int l = 0; l < LANES; l++)
      check($sformatf("vst_lane%0d", l), data_write[l], 32'(2 * l));
    check("vst_vec_scalar", 32'(vec_scalar), 32'h1);
    check("vst_memwrite", 32'(mem_write), 32'h1);
    check("vst_addr", 32'(addr), 32'h8);
    @(negedge clk); // D = BEQ taken
    check("beq_pc_before", pc, 32'd10);
    @(negedge clk); // bubble
    check("beq_bubble_nop", dut.fd_instr, 32'h0);
    check("beq_target_pc", pc, 32'd13);
    check("bubble_memwrite", 32'(mem_write), 32'h0);
    @(negedge clk); // D = BEQ not taken
    check("beq_nt_in_d", dut.fd_pc, 32'd13);
    @(negedge clk); // D = ADDI r7, no bubble
    check("beq_nt_no_bubble", dut.fd_pc, 32'd14);
    check("beq_nt_pc", pc, 32'd15);
    @(negedge clk); // D = JMP
    check("r7", dut.sreg_q[7], 32'd9);
    check("skipped_r6", dut.sreg_q[6], 32'd0);
    @(negedge clk); // bubble after JMP
    check("jmp_pc", pc, 32'd0);
    check("jmp_bubble_nop", dut.fd_instr, 32'h0);

    // Second pass up to the VST, then reset while it is in D.
    repeat (9) @(negedge clk);
    check("loop_vst_in_d", dut.fd_instr, 32'h80120003);
    check("loop_vst_memwrite", 32'(mem_write), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_kills_store", 32'(mem_write), 32'h0);
    dut.imem[0]   = 32'hA00000FE; // JMP 254
    dut.imem[254] = 32'h38000055; // ADDI r8,r0,0x55
    dut.imem[255] = 32'h39000066; // ADDI r9,r0,0x66
    @(negedge clk);
    check("midrst_pc", pc, 32'h0);
    check("midrst_r3", dut.sreg_q[3], 32'h0);
    check("midrst_v2", dut.vreg_q[2][5], 32'h0);
    check("midrst_fd_nop", dut.fd_instr, 32'h0);
    rst = 1'b0;

    repeat (3) @(negedge clk); // D = ADDI r8 at 254
    check("wrap_d254", dut.fd_pc, 32'd254);
    @(negedge clk);
    check("wrap_pc256", pc, 32'd256);
    @(negedge clk); // D = word fetched at pc 256 -> ROM[0]
    check("wrap_fetch_rom0", dut.fd_instr, 32'hA00000FE);
    check("wrap_fd_pc", dut.fd_pc, 32'd256);
    check("wrap_r8", dut.sreg_q[8], 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
